// File: rtl/ucsbece154b_icache_plru_if.sv
// Fetch-side and SDRAM-side signals of the instruction cache, grouped with cache (slave) and core/memory (master) views.
// No latency of its own; flow control is ready/busy toward fetch and memReadRequest/memDataReady toward memory.
interface ucsbece154b_icache_plru_if #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WORDS = 4
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);

    logic                 readEnable;
    logic [31:0]          readAddress;
    logic [WORD_SIZE-1:0] instruction;
    logic                 ready;
    logic                 busy;
    logic                 invalidate;
    logic [31:0]          memReadAddress;
    logic                 memReadRequest;
    logic [31:0]          memDataIn;
    logic                 memDataReady;
    logic [OFF_W-1:0]     memBlockIndex;

    modport slave (
        input  readEnable, readAddress, invalidate, memDataIn, memDataReady, memBlockIndex,
        output instruction, ready, busy, memReadAddress, memReadRequest
    );

    modport master (
        output readEnable, readAddress, invalidate, memDataIn, memDataReady, memBlockIndex,
        input  instruction, ready, busy, memReadAddress, memReadRequest
    );
endinterface

// File: rtl/ucsbece154b_icache_plru.sv
// Set-associative I-cache: hits return same cycle, misses refill critical-word-first and forward the missed beat.
// Stalls fetch (ready=0) while missing; busy during line install and set-by-set invalidate sweep.
module ucsbece154b_icache_plru #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32,
    parameter int REPL_MODE   = 1
) (
    input logic clk,
    input logic reset,
    ucsbece154b_icache_plru_if.slave bus
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = 30 - OFF_W - SET_W;
    localparam logic [WORD_SIZE-1:0] NOP       = WORD_SIZE'(32'h0000_0013);
    localparam logic [OFF_W-1:0]     LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [SET_W-1:0]     LAST_SET  = SET_W'(NUM_SETS - 1);

    typedef enum logic [2:0] {IDLE, MISS, REFILL, WRITE, FLUSH} state_t;
    state_t state, state_next;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid;
    logic [NUM_SETS-1:0][NUM_WAYS-1:1] plru;
    logic [TAG_W-1:0]     tags  [NUM_SETS][NUM_WAYS];
    logic [WORD_SIZE-1:0] lines [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [WORD_SIZE-1:0] line_buf [BLOCK_WORDS];

    logic [15:0]      lfsr;
    logic             inv_pending;
    logic [TAG_W-1:0] lat_tag;
    logic [SET_W-1:0] lat_set;
    logic [OFF_W-1:0] lat_off;
    logic [WAY_W-1:0] victim;
    logic [OFF_W-1:0] beat_cnt;
    logic [SET_W-1:0] flush_set;
    logic [31:0]      mem_addr;

    logic [OFF_W-1:0] rd_off;
    logic [SET_W-1:0] rd_set;
    logic [TAG_W-1:0] rd_tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] fill_way;
    logic             beat_fwd;
    logic             ready_c;
    logic             busy_c;
    logic [WORD_SIZE-1:0] instr_c;

    // Tree walk is keyed LSB-first: way bit 0 picks the root branch, so node 1 splits even/odd ways.
    function automatic logic [NUM_WAYS-1:1] plru_touch(input logic [NUM_WAYS-1:1] bits,
                                                       input logic [WAY_W-1:0] way);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        node = WAY_W'(1);
        w    = way;
        for (int l = 0; l < WAY_W; l++) begin
            bits[node] = ~w[0];
            node       = (node << 1) | WAY_W'(w[0]);
            w          = w >> 1;
        end
        return bits;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-1:1] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] v;
        logic             dir;
        node = WAY_W'(1);
        v    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = bits[node];
            v    = (v >> 1) | (WAY_W'(dir) << (WAY_W - 1));
            node = (node << 1) | WAY_W'(dir);
        end
        return v;
    endfunction

    assign rd_off = bus.readAddress[OFF_W+1:2];
    assign rd_set = bus.readAddress[OFF_W+SET_W+1:OFF_W+2];
    assign rd_tag = bus.readAddress[31:OFF_W+SET_W+2];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[rd_set][w] && tags[rd_set][w] == rd_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Descending scan leaves the lowest-index invalid way, overriding the replacement policy.
    always_comb begin
        fill_way = (REPL_MODE != 0) ? plru_victim(plru[rd_set]) : lfsr[WAY_W-1:0];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[rd_set][w]) fill_way = WAY_W'(w);
        end
    end

    assign beat_fwd = bus.memDataReady && (bus.memBlockIndex == lat_off);

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        instr_c    = NOP;
        case (state)
            IDLE: begin
                if (bus.invalidate) begin
                    state_next = FLUSH;
                end else if (bus.readEnable) begin
                    if (hit) begin
                        ready_c = 1'b1;
                        instr_c = lines[rd_set][hit_way][rd_off];
                    end else begin
                        state_next = MISS;
                    end
                end
            end
            MISS, REFILL: begin
                if (beat_fwd) begin
                    ready_c = 1'b1;
                    instr_c = WORD_SIZE'(bus.memDataIn);
                end
                if (state == MISS && bus.memDataReady) state_next = REFILL;
                if (state == REFILL && bus.memDataReady && beat_cnt == LAST_BEAT) state_next = WRITE;
            end
            WRITE: begin
                busy_c     = 1'b1;
                state_next = (inv_pending || bus.invalidate) ? FLUSH : IDLE;
            end
            FLUSH: begin
                busy_c = 1'b1;
                if (flush_set == LAST_SET) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            plru        <= '0;
            lfsr        <= 16'hA000;
            inv_pending <= 1'b0;
            lat_tag     <= '0;
            lat_set     <= '0;
            lat_off     <= '0;
            victim      <= '0;
            beat_cnt    <= '0;
            flush_set   <= '0;
            mem_addr    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (!bus.invalidate && bus.readEnable) begin
                        if (hit) begin
                            plru[rd_set] <= plru_touch(plru[rd_set], hit_way);
                        end else begin
                            lat_tag  <= rd_tag;
                            lat_set  <= rd_set;
                            lat_off  <= rd_off;
                            victim   <= fill_way;
                            beat_cnt <= '0;
                            mem_addr <= bus.readAddress & ~32'h3;
                            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                        end
                    end
                end
                MISS, REFILL: begin
                    if (bus.invalidate) inv_pending <= 1'b1;
                    if (bus.memDataReady) beat_cnt <= beat_cnt + 1'b1;
                end
                WRITE: begin
                    valid[lat_set][victim] <= 1'b1;
                    plru[lat_set]          <= plru_touch(plru[lat_set], victim);
                end
                FLUSH: begin
                    valid[flush_set] <= '0;
                    plru[flush_set]  <= '0;
                    flush_set        <= flush_set + 1'b1;
                    inv_pending      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if ((state == MISS || state == REFILL) && bus.memDataReady)
            line_buf[bus.memBlockIndex] <= WORD_SIZE'(bus.memDataIn);
        if (state == WRITE) begin
            tags[lat_set][victim] <= lat_tag;
            for (int k = 0; k < BLOCK_WORDS; k++)
                lines[lat_set][victim][k] <= line_buf[k];
        end
    end

    assign bus.ready          = ready_c;
    assign bus.busy           = busy_c;
    assign bus.instruction    = instr_c;
    assign bus.memReadRequest = (state == MISS);
    assign bus.memReadAddress = mem_addr;
endmodule

// File: tb/tb_ucsbece154b_icache_plru.sv
// Directed bench for the I-cache: refill ordering, forwarding, gaps, PLRU eviction, invalidate and async reset.
module tb_ucsbece154b_icache_plru;
    localparam int NS = 8;
    localparam int BW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [31:0] sb[$];

    ucsbece154b_icache_plru_if #(.WORD_SIZE(32), .BLOCK_WORDS(BW)) bus();

    ucsbece154b_icache_plru #(
        .NUM_SETS(NS), .NUM_WAYS(4), .BLOCK_WORDS(BW), .WORD_SIZE(32), .REPL_MODE(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a fixed function of the word address, never NOP.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, a[15:0] ^ 16'h5A00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_req"},   32'(bus.memReadRequest), 32'd0);
        chk({tag, "_maddr"}, bus.memReadAddress, 32'd0);
        chk({tag, "_instr"}, bus.instruction, NOP);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk_reset_outputs(tag);
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic read_hit(input logic [31:0] addr, input string tag);
        bus.readEnable  = 1'b1;
        bus.readAddress = addr;
        sb.push_back(mw(addr));
        #1;
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        pop_chk({tag, "_data"}, bus.instruction);
        step();
        bus.readEnable = 1'b0;
    endtask

    // start: index of first beat; gap_before: beat preceded by a 2-cycle memDataReady gap; inv_at: beat carrying an invalidate pulse.
    task automatic read_miss(input logic [31:0] addr, input int start, input int gap_before,
                             input int inv_at, input string tag);
        logic [31:0] base;
        int          off;
        int          idx;
        int          nbusy;
        base = addr & ~32'hF;
        off  = int'(addr[3:2]);
        bus.readEnable  = 1'b1;
        bus.readAddress = addr;
        #1;
        chk({tag, "_lookup_ready"}, 32'(bus.ready), 32'd0);
        sb.push_back(mw(addr));
        step();
        chk({tag, "_req"},   32'(bus.memReadRequest), 32'd1);
        chk({tag, "_maddr"}, bus.memReadAddress, addr & ~32'h3);
        for (int b = 0; b < BW; b++) begin
            if (b == gap_before) begin
                bus.memDataReady = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    #1;
                    chk({tag, "_gap_ready"}, 32'(bus.ready), 32'd0);
                    chk({tag, "_gap_req"},   32'(bus.memReadRequest), 32'd0);
                    chk({tag, "_gap_busy"},  32'(bus.busy), 32'd0);
                    step();
                end
            end
            idx = (start + b) % BW;
            bus.memDataReady  = 1'b1;
            bus.memBlockIndex = idx[1:0];
            bus.memDataIn     = mw(base + 32'(idx * 4));
            bus.invalidate    = (b == inv_at);
            #1;
            if (idx == off) begin
                chk({tag, "_fwd_ready"}, 32'(bus.ready), 32'd1);
                pop_chk({tag, "_fwd_data"}, bus.instruction);
            end else begin
                chk({tag, "_beat_ready"}, 32'(bus.ready), 32'd0);
            end
            step();
        end
        bus.memDataReady = 1'b0;
        bus.invalidate   = 1'b0;
        bus.readEnable   = 1'b0;
        bus.memDataIn    = '0;
        nbusy = (inv_at >= 0) ? 1 + NS : 1;
        for (int i = 0; i < nbusy; i++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_busy_ready"}, 32'(bus.ready), 32'd0);
            step();
        end
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset             = 1'b1;
        bus.readEnable    = 1'b0;
        bus.readAddress   = '0;
        bus.invalidate    = 1'b0;
        bus.memDataIn     = '0;
        bus.memDataReady  = 1'b0;
        bus.memBlockIndex = '0;
        #1;
        chk_reset_outputs("rst");
        step();
        reset = 1'b0;
        step();

        // Cold miss, in-order beats, then same-line hit.
        read_miss(32'h100, 0, -1, -1, "t1_miss");
        read_hit(32'h104, "t1_hit104");
        #1;
        chk("t1_noreq_ready", 32'(bus.ready), 32'd0);
        chk("t1_noreq_instr", bus.instruction, NOP);
        step();

        // Critical word first.
        pulse_reset("t2_rst");
        read_miss(32'h10C, 3, -1, -1, "t2_miss");
        read_hit(32'h100, "t2_hit100");
        read_hit(32'h108, "t2_hit108");

        // Gapped refill.
        read_miss(32'h230, 0, 2, -1, "t3_miss");
        read_hit(32'h230, "t3_hit0");
        read_hit(32'h234, "t3_hit1");
        read_hit(32'h238, "t3_hit2");
        read_hit(32'h23C, "t3_hit3");

        // PLRU eviction in set 0.
        pulse_reset("t4_rst");
        read_miss(32'h000, 0, -1, -1, "t4_fill0");
        read_miss(32'h080, 0, -1, -1, "t4_fill1");
        read_miss(32'h100, 0, -1, -1, "t4_fill2");
        read_miss(32'h180, 0, -1, -1, "t4_fill3");
        read_hit(32'h000, "t4_hitT0");
        read_miss(32'h200, 0, -1, -1, "t4_missT4");
        read_hit(32'h000, "t4_T0");
        read_hit(32'h100, "t4_T2");
        read_hit(32'h180, "t4_T3");
        read_hit(32'h200, "t4_T4");
        read_miss(32'h080, 0, -1, -1, "t4_T1_evicted");

        // Invalidate mid-refill: completes, then flush sweep.
        read_miss(32'h340, 0, -1, 1, "t5_inv");
        read_miss(32'h340, 0, -1, -1, "t5_remiss");
        read_miss(32'h200, 0, -1, -1, "t5_flushed_other");

        // Async reset during refill.
        bus.readEnable  = 1'b1;
        bus.readAddress = 32'h300;
        step();
        chk("t6_req", 32'(bus.memReadRequest), 32'd1);
        bus.memDataReady  = 1'b1;
        bus.memBlockIndex = 2'd1;
        bus.memDataIn     = mw(32'h304);
        step();
        bus.memBlockIndex = 2'd2;
        bus.memDataIn     = mw(32'h308);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("t6_rst");
        step();
        reset          = 1'b0;
        bus.readEnable = 1'b0;
        bus.memBlockIndex = 2'd0;
        bus.memDataIn     = mw(32'h300);
        #1;
        chk("t6_stray_ready", 32'(bus.ready), 32'd0);
        step();
        bus.memDataReady = 1'b0;
        step();
        read_miss(32'h300, 0, -1, -1, "t6_remiss");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
